operand_stack: RTL and testbench



---
 rtl/operand_stack.sv | 173 +++++++++++++++++
 tb/tb_operand_stack.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_stack.sv
// Operand stack feeding the ALU of the stack-machine datapath.
// The top entry is presented as operand a, the next one as operand b, and the
// ALU result s is written back according to the sequencer command. Any illegal
// command parks the block in a sticky error state until CLR arrives.
module operand_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_PUSH  = 3'd1;
    localparam logic [2:0] CMD_POP   = 3'd2;
    localparam logic [2:0] CMD_BINOP = 3'd3;
    localparam logic [2:0] CMD_UNOP  = 3'd4;
    localparam logic [2:0] CMD_DUP   = 3'd5;
    localparam logic [2:0] CMD_SWAP  = 3'd6;
    localparam logic [2:0] CMD_CLR   = 3'd7;

    localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [AW:0]        count_q, count_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];

    // Pointer is the entry count; the low AW bits address the next free slot,
    // and wrap-by-subtraction gives the top and second slots even when full.
    logic [AW-1:0]      ptr_push_s;
    logic [AW-1:0]      ptr_top_s;
    logic [AW-1:0]      ptr_sec_s;
    logic               empty_s;
    logic               full_s;
    logic               lt2_s;
    logic               illegal_s;

    assign ptr_push_s = count_q[AW-1:0];
    assign ptr_top_s  = ptr_push_s - AW'(1);
    assign ptr_sec_s  = ptr_push_s - AW'(2);
    assign empty_s    = (count_q == CNT_ZERO);
    assign full_s     = (count_q == CNT_FULL);
    assign lt2_s      = (count_q < CNT_TWO);

    // Operands come only from registered state, gated to zero when absent.
    assign a         = empty_s ? {WIDTH{1'b0}} : mem_q[ptr_top_s];
    assign b         = lt2_s   ? {WIDTH{1'b0}} : mem_q[ptr_sec_s];
    assign count     = count_q;
    assign empty     = empty_s;
    assign full      = full_s;
    assign err       = (state_q == ST_ERR);
    assign cmd_ready = (state_q == ST_RUN);

    // Decode the command into next count, next storage image and next state.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mem_d     = mem_q;
        illegal_s = 1'b0;
        if (cmd_valid) begin
            if (cmd == CMD_CLR) begin
                count_d = CNT_ZERO;
                state_d = ST_RUN;
            end else if (state_q == ST_RUN) begin
                case (cmd)
                    CMD_NOP: begin
                        count_d = count_q;
                    end
                    CMD_PUSH: begin
                        if (full_s) begin
                            illegal_s = 1'b1;
                        end else begin
                            mem_d[ptr_push_s] = din;
                            count_d           = count_q + CNT_ONE;
                        end
                    end
                    CMD_POP: begin
                        if (empty_s) begin
                            illegal_s = 1'b1;
                        end else begin
                            count_d = count_q - CNT_ONE;
                        end
                    end
                    CMD_BINOP: begin
                        if (lt2_s) begin
                            illegal_s = 1'b1;
                        end else begin
                            mem_d[ptr_sec_s] = s;
                            count_d          = count_q - CNT_ONE;
                        end
                    end
                    CMD_UNOP: begin
                        if (empty_s) begin
                            illegal_s = 1'b1;
                        end else begin
                            mem_d[ptr_top_s] = s;
                        end
                    end
                    CMD_DUP: begin
                        if (empty_s || full_s) begin
                            illegal_s = 1'b1;
                        end else begin
                            mem_d[ptr_push_s] = mem_q[ptr_top_s];
                            count_d           = count_q + CNT_ONE;
                        end
                    end
                    CMD_SWAP: begin
                        if (lt2_s) begin
                            illegal_s = 1'b1;
                        end else begin
                            mem_d[ptr_top_s] = mem_q[ptr_sec_s];
                            mem_d[ptr_sec_s] = mem_q[ptr_top_s];
                        end
                    end
                    default: begin
                        count_d = count_q;
                    end
                endcase
                if (illegal_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                state_d = ST_ERR;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Control state: run/error state and entry count, with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            count_q <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Entry storage: contents are don't-care after reset, so it is never cleared.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            mem_q <= mem_d;
        end else begin
            mem_q <= mem_q;
        end
    end

endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack: directed test-plan sequences with literal
// expectations, followed by randomized commands checked every cycle against
// a queue-based model of the stack.
module tb_operand_stack;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic        cmd_ready;
    logic [15:0] din;
    logic [15:0] s;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model: back of the queue is the top of the stack.
    logic [15:0] stk[$];
    bit          m_err = 1'b0;

    operand_stack #(.WIDTH(16), .DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .din(din), .s(s), .a(a), .b(b),
        .count(count), .empty(empty), .full(full), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] m_a();
        if (stk.size() > 0) return stk[stk.size()-1];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] m_b();
        if (stk.size() > 1) return stk[stk.size()-2];
        return 16'h0000;
    endfunction

    // ALU stand-in: 0 ADD, 1 SUB (b-a), 2 NEG (-a), 3 XOR, 4 AND
    function automatic logic [15:0] alu(input int f, input logic [15:0] x, input logic [15:0] y);
        case (f)
            0: return y + x;
            1: return y - x;
            2: return 16'h0000 - x;
            3: return y ^ x;
            default: return y & x;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update for one clock edge, using the pre-edge model state.
    task automatic model_edge(input bit r, input bit v, input logic [2:0] c,
                              input logic [15:0] d, input logic [15:0] sv);
        logic [15:0] t;
        int n;
        n = stk.size();
        if (!r) begin
            stk.delete();
            m_err = 1'b0;
        end else if (v) begin
            if (c == 3'd7) begin
                stk.delete();
                m_err = 1'b0;
            end else if (!m_err) begin
                case (c)
                    3'd1: if (n == 16) m_err = 1'b1; else stk.push_back(d);
                    3'd2: if (n == 0) m_err = 1'b1; else t = stk.pop_back();
                    3'd3: if (n < 2) m_err = 1'b1;
                          else begin t = stk.pop_back(); t = stk.pop_back(); stk.push_back(sv); end
                    3'd4: if (n == 0) m_err = 1'b1; else stk[n-1] = sv;
                    3'd5: if (n == 0 || n == 16) m_err = 1'b1; else stk.push_back(stk[n-1]);
                    3'd6: if (n < 2) m_err = 1'b1;
                          else begin t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t; end
                    default: ;
                endcase
            end
        end
    endtask

    // Drive one cycle of stimulus; s is the ALU result on the current operands.
    task automatic step(input bit r, input bit v, input logic [2:0] c,
                        input logic [15:0] d, input int f);
        rst_n     = r;
        cmd_valid = v;
        cmd       = c;
        din       = d;
        s         = alu(f, m_a(), m_b());
        @(posedge clk);
        model_edge(r, v, c, d, s);
        @(negedge clk);
        #1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a", {16'h0, a}, {16'h0, m_a()});
            check("b", {16'h0, b}, {16'h0, m_b()});
            check("count", {27'h0, count}, stk.size());
            check("empty", {31'h0, empty}, {31'h0, stk.size() == 0});
            check("full", {31'h0, full}, {31'h0, stk.size() == 16});
            check("err", {31'h0, err}, {31'h0, m_err});
            check("cmd_ready", {31'h0, cmd_ready}, {31'h0, !m_err});
        end
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; din = 16'h0; s = 16'h0;
        step(1'b0, 1'b0, 3'd0, 16'h0, 0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 0);
        chk_en = 1'b1;

        // Reset state
        check("rst_count", {27'h0, count}, 32'd0);
        check("rst_a", {16'h0, a}, 32'd0);
        check("rst_empty", {31'h0, empty}, 32'd1);
        check("rst_ready", {31'h0, cmd_ready}, 32'd1);

        // PUSH 5, PUSH 3, BINOP SUB
        step(1'b1, 1'b1, 3'd1, 16'd5, 0);
        step(1'b1, 1'b1, 3'd1, 16'd3, 0);
        check("tp1_a", {16'h0, a}, 32'd3);
        check("tp1_b", {16'h0, b}, 32'd5);
        step(1'b1, 1'b1, 3'd3, 16'h0, 1);
        check("tp1_cnt", {27'h0, count}, 32'd1);
        check("tp1_s", {16'h0, a}, 32'd2);
        check("tp1_b0", {16'h0, b}, 32'd0);

        // 7FFF, NEG, DUP, SWAP
        step(1'b1, 1'b1, 3'd7, 16'h0, 0);
        step(1'b1, 1'b1, 3'd1, 16'h7FFF, 0);
        step(1'b1, 1'b1, 3'd4, 16'h0, 2);
        check("tp2_neg", {16'h0, a}, 32'h8001);
        check("tp2_cnt", {27'h0, count}, 32'd1);
        step(1'b1, 1'b1, 3'd5, 16'h0, 0);
        check("tp2_dup_a", {16'h0, a}, 32'h8001);
        check("tp2_dup_b", {16'h0, b}, 32'h8001);
        check("tp2_dup_cnt", {27'h0, count}, 32'd2);
        step(1'b1, 1'b1, 3'd6, 16'h0, 0);
        check("tp2_swap_a", {16'h0, a}, 32'h8001);

        // Fill to DEPTH, then overflow
        step(1'b1, 1'b1, 3'd7, 16'h0, 0);
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b1, 3'd1, 16'(i), 0);
        check("tp3_full", {31'h0, full}, 32'd1);
        check("tp3_a", {16'h0, a}, 32'd16);
        check("tp3_b", {16'h0, b}, 32'd15);
        step(1'b1, 1'b1, 3'd1, 16'd99, 0);
        check("tp3_err", {31'h0, err}, 32'd1);
        check("tp3_cnt", {27'h0, count}, 32'd16);
        check("tp3_a2", {16'h0, a}, 32'd16);
        check("tp3_ready", {31'h0, cmd_ready}, 32'd0);

        // Commands ignored in ERR, then CLR
        step(1'b1, 1'b1, 3'd1, 16'd7, 0);
        step(1'b1, 1'b1, 3'd2, 16'd0, 0);
        step(1'b1, 1'b1, 3'd3, 16'd0, 0);
        check("tp4_cnt", {27'h0, count}, 32'd16);
        check("tp4_a", {16'h0, a}, 32'd16);
        check("tp4_err", {31'h0, err}, 32'd1);
        step(1'b1, 1'b1, 3'd7, 16'h0, 0);
        check("tp4_clr_cnt", {27'h0, count}, 32'd0);
        check("tp4_clr_err", {31'h0, err}, 32'd0);
        check("tp4_clr_rdy", {31'h0, cmd_ready}, 32'd1);
        check("tp4_clr_emp", {31'h0, empty}, 32'd1);

        // Underflow cases
        step(1'b1, 1'b1, 3'd2, 16'h0, 0);
        check("tp5_pop_err", {31'h0, err}, 32'd1);
        check("tp5_pop_cnt", {27'h0, count}, 32'd0);
        step(1'b1, 1'b1, 3'd7, 16'h0, 0);
        step(1'b1, 1'b1, 3'd1, 16'h1234, 0);
        step(1'b1, 1'b1, 3'd3, 16'h0, 0);
        check("tp5_bin_err", {31'h0, err}, 32'd1);
        check("tp5_bin_cnt", {27'h0, count}, 32'd1);
        check("tp5_bin_a", {16'h0, a}, 32'h1234);

        // cmd_valid low, then reset colliding with a push
        step(1'b1, 1'b1, 3'd7, 16'h0, 0);
        step(1'b1, 1'b0, 3'd1, 16'd9, 0);
        check("tp6_nv_cnt", {27'h0, count}, 32'd0);
        step(1'b1, 1'b1, 3'd1, 16'd4, 0);
        step(1'b0, 1'b1, 3'd1, 16'd8, 0);
        check("tp6_rst_cnt", {27'h0, count}, 32'd0);
        check("tp6_rst_err", {31'h0, err}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, v;
            logic [2:0] c;
            r = ($urandom_range(0, 299) != 0);
            v = ($urandom_range(0, 9) != 0);
            if (m_err && $urandom_range(0, 2) == 0) c = 3'd7;
            else if ($urandom_range(0, 39) == 0) c = 3'd7;
            else if ($urandom_range(0, 2) == 0) c = 3'd1;
            else c = 3'($urandom_range(0, 6));
            step(r, v, c, 16'($urandom), int'($urandom_range(0, 4)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
